// File: rtl/keypad_scan_entry_if.sv
// ============================================================================
// Module      : keypad_scan_entry_if
// Description : Result bus from the keypad scanner/entry block to the main
//               controller: last key event, entry in progress and the two
//               committed 7-bit fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scan_entry_if;
  logic [3:0] key_code;   // index of last pressed key, row*4 + col
  logic       key_valid;  // one-cycle pulse per new press
  logic [6:0] entry_val;  // value currently being typed (0..99)
  logic [1:0] entry_cnt;  // digits typed (0..2)
  logic       sel;        // ENTER target: 0 = numb, 1 = nums
  logic [6:0] numb;       // committed field 0
  logic [6:0] nums;       // committed field 1
  logic       num_valid;  // one-cycle pulse when numb or nums is written

  // Producer side (the keypad block)
  modport master (
    output key_code, key_valid, entry_val, entry_cnt,
    output sel, numb, nums, num_valid
  );

  // Consumer side (main state machine)
  modport slave (
    input key_code, key_valid, entry_val, entry_cnt,
    input sel, numb, nums, num_valid
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scan_entry.sv
// ============================================================================
// Module      : keypad_scan_entry
// Description : 4x4 matrix keypad scanner with debounce, press detection and
//               two-digit decimal entry committed into numb / nums.
//               Optional macro KEYPAD_MULTI_REJECT_EN: when defined, scans with
//               more than one key down are treated as "no key", so chords
//               never produce an event.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan_entry #(
  parameter int SCAN_DIV       = 50000, // clk cycles per column slot, >= 2
  parameter int DEBOUNCE_SCANS = 4      // identical full scans to commit, >= 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 key_row,     // active low, pulled up
  output logic [3:0]                 key_column,  // one-hot active low
  keypad_scan_entry_if.master        bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_deb_w = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_SCANS - 1);

  // Function-key codes (k = row*4 + col)
  localparam logic [3:0] c_key_bksp = 4'd3;
  localparam logic [3:0] c_key_clr  = 4'd7;
  localparam logic [3:0] c_key_ent  = 4'd11;
  localparam logic [3:0] c_key_sel  = 4'd15;

  // --------------------------------------------------------------------------
  // Scan / debounce state
  // --------------------------------------------------------------------------
  logic [c_div_w-1:0] div_q,  div_d;    // column-slot divider
  logic [1:0]         col_q,  col_d;    // active column
  logic [15:0]        snap_q, snap_d;   // snapshot being assembled
  logic [15:0]        prev_q, prev_d;   // last complete (filtered) scan
  logic [c_deb_w-1:0] stab_q, stab_d;   // consecutive identical scans - 1
  logic [15:0]        deb_q,  deb_d;    // debounced key state

  // Key event outputs
  logic [3:0]         key_code_q,  key_code_d;
  logic               key_valid_q, key_valid_d;

  // Entry / commit state
  logic [6:0]         entry_val_q, entry_val_d;
  logic [1:0]         entry_cnt_q, entry_cnt_d;
  logic               sel_q,       sel_d;
  logic [6:0]         numb_q,      numb_d;
  logic [6:0]         nums_q,      nums_d;
  logic               num_valid_q, num_valid_d;

  // Combinational helpers
  logic [15:0]        col_mask;     // snapshot bits owned by the active column
  logic [15:0]        row_spread;   // pressed rows placed at bit r*4
  logic [15:0]        scan_full;    // completed snapshot after chord filtering
  logic [3:0]         low_idx;      // lowest set index of scan_full
  logic               press;        // released -> pressed transition commits
  logic               digit_ok;     // key_code_q is a digit key
  logic [3:0]         digit;        // decimal value of that digit key

  // Column drive follows the column index; reset leaves col 0 active (1110)
  assign key_column = ~(4'b0001 << col_q);

  // Pressed rows for the active column, pre-positioned for a shift by col
  assign row_spread = {3'b000, ~key_row[3], 3'b000, ~key_row[2],
                       3'b000, ~key_row[1], 3'b000, ~key_row[0]};
  assign col_mask   = 16'h1111 << col_q;

  // Divider, column stepping, snapshot capture and debounce next-state
  always_comb begin
    div_d       = div_q;
    col_d       = col_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    deb_d       = deb_q;
    scan_full   = prev_q;
    press       = 1'b0;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    low_idx     = 4'd0;

    if (div_q == c_div_last) begin
      div_d  = '0;
      col_d  = col_q + 2'd1;
      snap_d = (snap_q & ~col_mask) | (row_spread << col_q);

      // Column 3 just landed: the snapshot now describes a whole scan
      if (col_q == 2'd3) begin
`ifdef KEYPAD_MULTI_REJECT_EN
        // More than one bit set -> behave as if nothing is pressed
        scan_full = ((snap_d & (snap_d - 16'd1)) != 16'd0) ? 16'd0 : snap_d;
`else
        scan_full = snap_d;
`endif
        prev_d = scan_full;

        if (scan_full == prev_q) begin
          stab_d = (stab_q == c_deb_last) ? stab_q : stab_q + c_deb_w'(1);
        end else begin
          stab_d = '0;
        end

        if ((stab_d == c_deb_last) && (scan_full != deb_q)) begin
          deb_d = scan_full;
          // Only a transition out of "all released" is a new press
          press = (deb_q == 16'd0) && (scan_full != 16'd0);
        end
      end
    end else begin
      div_d = div_q + c_div_w'(1);
    end

    // Lowest pressed index wins when several keys are down
    for (int i = 15; i >= 0; i--) begin
      if (scan_full[i]) begin
        low_idx = 4'(i);
      end
    end

    if (press) begin
      key_code_d  = low_idx;
      key_valid_d = 1'b1;
    end
  end

  // Digit decode of the last pressed key
  always_comb begin
    digit_ok = 1'b1;
    digit    = 4'd0;
    case (key_code_q)
      4'd0:    digit = 4'd1;
      4'd1:    digit = 4'd2;
      4'd2:    digit = 4'd3;
      4'd4:    digit = 4'd4;
      4'd5:    digit = 4'd5;
      4'd6:    digit = 4'd6;
      4'd8:    digit = 4'd7;
      4'd9:    digit = 4'd8;
      4'd10:   digit = 4'd9;
      4'd13:   digit = 4'd0;
      default: digit_ok = 1'b0;
    endcase
  end

  // Entry editing and field commit, acting on the cycle key_valid is high
  always_comb begin
    entry_val_d = entry_val_q;
    entry_cnt_d = entry_cnt_q;
    sel_d       = sel_q;
    numb_d      = numb_q;
    nums_d      = nums_q;
    num_valid_d = 1'b0;

    if (key_valid_q) begin
      if (digit_ok) begin
        // Two digits max; 9*10+9 = 99 always fits in 7 bits
        if (entry_cnt_q < 2'd2) begin
          entry_val_d = entry_val_q * 7'd10 + {3'b000, digit};
          entry_cnt_d = entry_cnt_q + 2'd1;
        end
      end else begin
        case (key_code_q)
          c_key_bksp: begin
            if (entry_cnt_q != 2'd0) begin
              entry_val_d = entry_val_q / 7'd10;
              entry_cnt_d = entry_cnt_q - 2'd1;
            end
          end
          c_key_clr: begin
            entry_val_d = 7'd0;
            entry_cnt_d = 2'd0;
          end
          c_key_ent: begin
            // An empty entry is not committed
            if (entry_cnt_q != 2'd0) begin
              if (sel_q) begin
                nums_d = entry_val_q;
              end else begin
                numb_d = entry_val_q;
              end
              num_valid_d = 1'b1;
              entry_val_d = 7'd0;
              entry_cnt_d = 2'd0;
            end
          end
          c_key_sel: begin
            sel_d       = ~sel_q;
            entry_val_d = 7'd0;
            entry_cnt_d = 2'd0;
          end
          default: ; // k12 / k14: event only
        endcase
      end
    end
  end

  // State registers, all cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      snap_q      <= 16'd0;
      prev_q      <= 16'd0;
      stab_q      <= '0;
      deb_q       <= 16'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      entry_val_q <= 7'd0;
      entry_cnt_q <= 2'd0;
      sel_q       <= 1'b0;
      numb_q      <= 7'd0;
      nums_q      <= 7'd0;
      num_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_val_q <= entry_val_d;
      entry_cnt_q <= entry_cnt_d;
      sel_q       <= sel_d;
      numb_q      <= numb_d;
      nums_q      <= nums_d;
      num_valid_q <= num_valid_d;
    end
  end

  // Result bus
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.entry_val = entry_val_q;
  assign bus.entry_cnt = entry_cnt_q;
  assign bus.sel       = sel_q;
  assign bus.numb      = numb_q;
  assign bus.nums      = nums_q;
  assign bus.num_valid = num_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_entry.sv
// ============================================================================
// Module      : tb_keypad_scan_entry
// Description : Self-checking bench for keypad_scan_entry with a keypad
//               matrix model and scoreboard queues for key and commit events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scan_entry;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN           = 4 * SCAN_DIV;

  typedef struct packed {
    logic       fld;   // 0 = numb, 1 = nums
    logic [6:0] val;
  } num_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_row;
  logic [3:0]  key_column;
  logic [15:0] pressed = 16'd0;   // physical keys held down, bit k

  logic [3:0]  kq[$];             // expected key codes
  num_t        nq[$];             // expected field commits
  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  ek;
  num_t        en;
  logic [6:0]  got_field;

  keypad_scan_entry_if kif ();

  keypad_scan_entry #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_row    (key_row),
    .key_column (key_column),
    .bus        (kif)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low when a held key sits on the driven column
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(pressed[r*4 +: 4] & ~key_column)) key_row[r] = 1'b0;
    end
  end

  // Key event scoreboard
  always @(negedge clk) begin
    if (rst_n && kif.key_valid) begin
      n_cmp++;
      if (kq.size() == 0) begin
        n_err++;
        $display("FAIL key_event_unexpected: got code %0d expected no event", kif.key_code);
      end else begin
        ek = kq.pop_front();
        if (kif.key_code !== ek) begin
          n_err++;
          $display("FAIL key_code: got %0d expected %0d", kif.key_code, ek);
        end
      end
    end
  end

  // Commit scoreboard: field must already hold the new value while num_valid
  always @(negedge clk) begin
    if (rst_n && kif.num_valid) begin
      n_cmp++;
      if (nq.size() == 0) begin
        n_err++;
        $display("FAIL num_valid_unexpected: got numb=%0d nums=%0d expected no commit",
                 kif.numb, kif.nums);
      end else begin
        en = nq.pop_front();
        got_field = en.fld ? kif.nums : kif.numb;
        if (got_field !== en.val) begin
          n_err++;
          $display("FAIL commit_field%0d: got %0d expected %0d", en.fld, got_field, en.val);
        end
      end
    end
  end

  // Hold keys until an event (or a full window), then hold, then release
  task automatic hold_keys(input logic [15:0] keys, input int exp_code, input string name);
    bit got = 1'b0;
    bit want = (exp_code >= 0);
    if (want) kq.push_back(4'(exp_code));
    pressed = keys;
    for (int i = 0; i < 10 * SCAN; i++) begin
      @(negedge clk);
      if (kif.key_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s_event: got %0d expected %0d", name, got, want);
      kq.delete();
    end
    repeat (3 * SCAN) @(negedge clk);
    pressed = 16'd0;
    repeat (4 * SCAN) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({kif.key_code, kif.key_valid, kif.entry_val, kif.entry_cnt, kif.sel,
         kif.numb, kif.nums, kif.num_valid} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got code=%0d kv=%0d val=%0d cnt=%0d sel=%0d numb=%0d nums=%0d nv=%0d expected all 0",
               kif.key_code, kif.key_valid, kif.entry_val, kif.entry_cnt, kif.sel,
               kif.numb, kif.nums, kif.num_valid);
    end
    n_cmp++;
    if (key_column !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_key_column: got %b expected 1110", key_column);
    end
    kq.delete();
    nq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    hold_keys(16'd1 << 5, 5, "k5");
    n_cmp++;
    if (kif.entry_val !== 7'd5 || kif.entry_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL single_entry: got %0d/%0d expected 5/1", kif.entry_val, kif.entry_cnt);
    end
  endtask

  task automatic test_digits();
    hold_keys(16'd1 << 7, 7, "clr");
    n_cmp++;
    if (kif.entry_val !== 7'd0 || kif.entry_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clr_entry: got %0d/%0d expected 0/0", kif.entry_val, kif.entry_cnt);
    end
    hold_keys(16'd1 << 0, 0, "k0");
    hold_keys(16'd1 << 9, 9, "k9");
    hold_keys(16'd1 << 10, 10, "k10");
    n_cmp++;
    if (kif.entry_val !== 7'd18 || kif.entry_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL two_digit_entry: got %0d/%0d expected 18/2", kif.entry_val, kif.entry_cnt);
    end
    hold_keys(16'd1 << 3, 3, "bksp");
    n_cmp++;
    if (kif.entry_val !== 7'd1 || kif.entry_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL bksp_entry: got %0d/%0d expected 1/1", kif.entry_val, kif.entry_cnt);
    end
  endtask

  task automatic test_enter();
    hold_keys(16'd1 << 7, 7, "clr");
    hold_keys(16'd1 << 4, 4, "k4");
    hold_keys(16'd1 << 1, 1, "k1");
    n_cmp++;
    if (kif.entry_val !== 7'd42 || kif.entry_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL entry_42: got %0d/%0d expected 42/2", kif.entry_val, kif.entry_cnt);
    end
    nq.push_back('{fld: 1'b0, val: 7'd42});
    hold_keys(16'd1 << 11, 11, "ent");
    n_cmp++;
    if (kif.numb !== 7'd42 || kif.entry_cnt !== 2'd0 || kif.entry_val !== 7'd0 || nq.size() != 0) begin
      n_err++;
      $display("FAIL enter_numb: got numb=%0d entry=%0d/%0d pending=%0d expected 42 0/0 0",
               kif.numb, kif.entry_val, kif.entry_cnt, nq.size());
    end
    hold_keys(16'd1 << 15, 15, "sel");
    n_cmp++;
    if (kif.sel !== 1'b1) begin
      n_err++;
      $display("FAIL sel_toggle: got %0d expected 1", kif.sel);
    end
    hold_keys(16'd1 << 8, 8, "k8");
    nq.push_back('{fld: 1'b1, val: 7'd7});
    hold_keys(16'd1 << 11, 11, "ent");
    n_cmp++;
    if (kif.nums !== 7'd7 || kif.numb !== 7'd42 || nq.size() != 0) begin
      n_err++;
      $display("FAIL enter_nums: got nums=%0d numb=%0d pending=%0d expected 7 42 0",
               kif.nums, kif.numb, nq.size());
    end
  endtask

  task automatic test_enter_empty();
    hold_keys(16'd1 << 11, 11, "ent_empty");
    n_cmp++;
    if (kif.numb !== 7'd42 || kif.nums !== 7'd7) begin
      n_err++;
      $display("FAIL enter_empty: got numb=%0d nums=%0d expected 42 7", kif.numb, kif.nums);
    end
    hold_keys(16'd1 << 0, 0, "k0");
    hold_keys(16'd1 << 7, 7, "clr");
    n_cmp++;
    if (kif.entry_val !== 7'd0 || kif.entry_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clr_after_digit: got %0d/%0d expected 0/0", kif.entry_val, kif.entry_cnt);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? (16'd1 << 5) : 16'd0;
      repeat (SCAN) @(negedge clk);
    end
    pressed = 16'd0;
    repeat (4 * SCAN) @(negedge clk);
    n_cmp++;
    if (kif.entry_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL bounce_entry: got cnt %0d expected 0", kif.entry_cnt);
    end
    hold_keys(16'd1 << 5, 5, "k5_stable");
    n_cmp++;
    if (kif.entry_val !== 7'd5 || kif.entry_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL bounce_then_stable: got %0d/%0d expected 5/1", kif.entry_val, kif.entry_cnt);
    end
  endtask

  task automatic test_reset_mid_entry();
    hold_keys(16'd1 << 4, 4, "k4");
    n_cmp++;
    if (kif.entry_val !== 7'd54 || kif.entry_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL entry_54: got %0d/%0d expected 54/2", kif.entry_val, kif.entry_cnt);
    end
    pressed = 16'd1 << 6;
    repeat (8) @(negedge clk);
    test_reset();
    hold_keys(16'd1 << 6, 6, "k6_after_reset");
    n_cmp++;
    if (kif.entry_val !== 7'd6 || kif.entry_cnt !== 2'd1 || kif.sel !== 1'b0 || kif.numb !== 7'd0) begin
      n_err++;
      $display("FAIL after_reset_entry: got val=%0d cnt=%0d sel=%0d numb=%0d expected 6 1 0 0",
               kif.entry_val, kif.entry_cnt, kif.sel, kif.numb);
    end
  endtask

  task automatic test_multi();
    hold_keys(16'd1 << 7, 7, "clr");
`ifdef KEYPAD_MULTI_REJECT_EN
    hold_keys(16'h0003, -1, "chord");
    pressed = 16'h0003;
    repeat (4 * SCAN) @(negedge clk);
    hold_keys(16'h0002, 1, "chord_to_k1");
    n_cmp++;
    if (kif.entry_val !== 7'd2 || kif.entry_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL chord_release_entry: got %0d/%0d expected 2/1", kif.entry_val, kif.entry_cnt);
    end
`else
    hold_keys(16'h0003, 0, "chord");
    n_cmp++;
    if (kif.entry_val !== 7'd1 || kif.entry_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL chord_lowest_entry: got %0d/%0d expected 1/1", kif.entry_val, kif.entry_cnt);
    end
`endif
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_press();
    test_digits();
    test_enter();
    test_enter_empty();
    test_bounce();
    test_reset_mid_entry();
    test_multi();
    n_cmp++;
    if (kq.size() != 0 || nq.size() != 0) begin
      n_err++;
      $display("FAIL pending_events: got %0d/%0d expected 0/0", kq.size(), nq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
